// File: rtl/riscv_pkg.sv
// Base RISC-V ISA parameters shared across the core.
package riscv_pkg;

  localparam int MXLEN = 32;

endpackage

// File: rtl/riscv_privileged_pkg.sv
// Privileged-architecture types: CSR addressing, the CSR command bus and Zicsr decode.
package riscv_privileged_pkg;

  typedef logic [11:0] csr_address_t;

  typedef enum logic [1:0] {
    NONE           = 2'd0,
    READ_ONLY      = 2'd1,
    WRITE_ONLY     = 2'd2,
    WRITE_AND_READ = 2'd3
  } csr_command_t;

  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_funct3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } csr_access_state_t;

endpackage

// File: rtl/csr_access_unit.sv
// Zicsr executor: turns one CSR instruction into at most one read and one write on the
// exception_handler CSR bus and returns the old CSR value (or an illegal flag) to the core.
module csr_access_unit
  import riscv_pkg::*;
  import riscv_privileged_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  csr_address_t     req_csr_address_i,
  input  logic [MXLEN-1:0] req_rs1_value_i,
  input  logic [4:0]       req_rs1_index_i,
  input  logic [4:0]       req_rd_index_i,
  output csr_address_t     csr_address_o,
  output csr_command_t     csr_command_o,
  output logic [MXLEN-1:0] csr_write_data_o,
  input  logic [MXLEN-1:0] csr_read_data_i,
  input  logic             csr_read_data_valid_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [4:0]       rsp_rd_index_o,
  output logic [MXLEN-1:0] rsp_rd_data_o,
  output logic             rsp_illegal_o
);

  csr_access_state_t state_q;
  logic [1:0]        funct3_q;
  logic [MXLEN-1:0]  operand_q;
  logic              write_int_q;
  logic              pre_illegal_q;

  // Request decode, evaluated on the incoming fields so ACCESS can drive a registered command.
  logic [MXLEN-1:0] operand_d;
  logic             is_rw_d;
  logic             write_int_d;
  logic             illegal_d;
  csr_command_t     cmd_d;

  assign operand_d   = req_funct3_i[2] ? {{(MXLEN-5){1'b0}}, req_rs1_index_i} : req_rs1_value_i;
  assign is_rw_d     = (req_funct3_i[1:0] == 2'b01);
  assign write_int_d = is_rw_d || (req_rs1_index_i != 5'd0);
  assign illegal_d   = (req_funct3_i[1:0] == 2'b00) ||
                       (write_int_d && (req_csr_address_i[11:10] == 2'b11));

  always_comb begin
    cmd_d = READ_ONLY;
    if (illegal_d)    cmd_d = NONE;
    else if (is_rw_d) cmd_d = (req_rd_index_i != 5'd0) ? WRITE_AND_READ : WRITE_ONLY;
  end

  logic [MXLEN-1:0] set_clr_data;
  logic [MXLEN-1:0] rd_value;
  assign set_clr_data = funct3_q[0] ? (csr_read_data_i & ~operand_q)
                                    : (csr_read_data_i | operand_q);
  assign rd_value     = (rsp_rd_index_o != 5'd0) ? csr_read_data_i : '0;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q          <= IDLE;
      funct3_q         <= '0;
      operand_q        <= '0;
      write_int_q      <= 1'b0;
      pre_illegal_q    <= 1'b0;
      req_ready_o      <= 1'b1;
      csr_address_o    <= '0;
      csr_command_o    <= NONE;
      csr_write_data_o <= '0;
      rsp_valid_o      <= 1'b0;
      rsp_rd_index_o   <= '0;
      rsp_rd_data_o    <= '0;
      rsp_illegal_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            state_q          <= ACCESS;
            req_ready_o      <= 1'b0;
            funct3_q         <= req_funct3_i[1:0];
            operand_q        <= operand_d;
            write_int_q      <= write_int_d;
            pre_illegal_q    <= illegal_d;
            csr_address_o    <= req_csr_address_i;
            rsp_rd_index_o   <= req_rd_index_i;
            rsp_illegal_o    <= 1'b0;
            rsp_rd_data_o    <= '0;
            csr_command_o    <= cmd_d;
            csr_write_data_o <= (is_rw_d && !illegal_d) ? operand_d : '0;
          end
        end
        ACCESS: begin
          csr_command_o    <= NONE;
          csr_write_data_o <= '0;
          if (pre_illegal_q || !csr_read_data_valid_i) begin
            state_q       <= RESP;
            rsp_valid_o   <= 1'b1;
            rsp_illegal_o <= 1'b1;
            rsp_rd_data_o <= '0;
          end else if (funct3_q[1] && write_int_q) begin
            // Set/clear: the modify-write uses the value read at this very edge.
            state_q          <= WRITE;
            rsp_rd_data_o    <= rd_value;
            csr_command_o    <= WRITE_ONLY;
            csr_write_data_o <= set_clr_data;
          end else begin
            state_q       <= RESP;
            rsp_valid_o   <= 1'b1;
            rsp_rd_data_o <= rd_value;
          end
        end
        WRITE: begin
          state_q          <= RESP;
          rsp_valid_o      <= 1'b1;
          csr_command_o    <= NONE;
          csr_write_data_o <= '0;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small exception_handler CSR file stand-in.
module tb_csr_access_unit;
  import riscv_pkg::*;
  import riscv_privileged_pkg::*;

  logic             clock_i = 1'b0;
  logic             reset_ni;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       req_funct3_i;
  csr_address_t     req_csr_address_i;
  logic [MXLEN-1:0] req_rs1_value_i;
  logic [4:0]       req_rs1_index_i;
  logic [4:0]       req_rd_index_i;
  csr_address_t     csr_address_o;
  csr_command_t     csr_command_o;
  logic [MXLEN-1:0] csr_write_data_o;
  logic [MXLEN-1:0] csr_read_data_i;
  logic             csr_read_data_valid_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [4:0]       rsp_rd_index_o;
  logic [MXLEN-1:0] rsp_rd_data_o;
  logic             rsp_illegal_o;

  csr_access_unit dut (
    .clock_i(clock_i), .reset_ni(reset_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_funct3_i(req_funct3_i),
    .req_csr_address_i(req_csr_address_i), .req_rs1_value_i(req_rs1_value_i),
    .req_rs1_index_i(req_rs1_index_i), .req_rd_index_i(req_rd_index_i),
    .csr_address_o(csr_address_o), .csr_command_o(csr_command_o),
    .csr_write_data_o(csr_write_data_o), .csr_read_data_i(csr_read_data_i),
    .csr_read_data_valid_i(csr_read_data_valid_i), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_rd_index_o(rsp_rd_index_o),
    .rsp_rd_data_o(rsp_rd_data_o), .rsp_illegal_o(rsp_illegal_o)
  );

  always #5 clock_i = ~clock_i;

  // CSR file stand-in: mtvec, mie, read-only mvendorid; anything else does not exist.
  logic [31:0] mtvec_m = 32'h1234_0000;
  logic [31:0] mie_m   = 32'h0;
  int          wr_cnt  = 0;

  always_comb begin
    csr_read_data_i       = '0;
    csr_read_data_valid_i = 1'b0;
    case (csr_address_o)
      12'h305: begin csr_read_data_i = mtvec_m;      csr_read_data_valid_i = 1'b1; end
      12'h304: begin csr_read_data_i = mie_m;        csr_read_data_valid_i = 1'b1; end
      12'hF11: begin csr_read_data_i = 32'h0000_0ABC; csr_read_data_valid_i = 1'b1; end
      default: ;
    endcase
  end

  always @(posedge clock_i) begin
    if (csr_command_o == WRITE_ONLY || csr_command_o == WRITE_AND_READ) begin
      wr_cnt <= wr_cnt + 1;
      if (csr_address_o == 12'h305) mtvec_m <= csr_write_data_o;
      if (csr_address_o == 12'h304) mie_m   <= csr_write_data_o;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer a request at the negedge; returns #1 after the handshake edge (state ACCESS).
  task automatic send(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] val,
                      input logic [4:0] idx, input logic [4:0] rd);
    @(negedge clock_i);
    req_valid_i = 1'b1; req_funct3_i = f3; req_csr_address_i = addr;
    req_rs1_value_i = val; req_rs1_index_i = idx; req_rd_index_i = rd;
    @(posedge clock_i); #1;
    req_valid_i = 1'b0; req_rs1_value_i = '0;
  endtask

  // Counts edges from the handshake edge (edge 1) until rsp_valid_o; bounded.
  task automatic wait_rsp(input int start, output int l);
    l = start;
    while (!rsp_valid_o && l < 12) begin
      @(posedge clock_i); #1;
      l++;
    end
  endtask

  task automatic check_rsp(input string tag, input int exp_lat, input logic [31:0] exp_data,
                           input logic exp_ill, input logic [4:0] exp_rd);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, rsp_rd_data_o, exp_data);
    chk({tag, "_ill"}, 32'(rsp_illegal_o), 32'(exp_ill));
    chk({tag, "_rd"}, 32'(rsp_rd_index_o), 32'(exp_rd));
    @(posedge clock_i); #1;
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    reset_ni = 1'b0; req_valid_i = 1'b0; req_funct3_i = '0; req_csr_address_i = '0;
    req_rs1_value_i = '0; req_rs1_index_i = '0; req_rd_index_i = '0; rsp_ready_i = 1'b1;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i) reset_ni = 1'b1;
    #2;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_cmd",   32'(csr_command_o), 32'(NONE));
    chk("rst_ill",   32'(rsp_illegal_o), 32'd0);
    chk("rst_addr",  32'(csr_address_o), 32'd0);
    chk("rst_wdata", csr_write_data_o, 32'd0);

    // CSRRW mtvec, rd=5
    send(CSRRW, 12'h305, 32'h8000_0000, 5'd1, 5'd5);
    chk("rw_cmd",   32'(csr_command_o), 32'(WRITE_AND_READ));
    chk("rw_wdata", csr_write_data_o, 32'h8000_0000);
    chk("rw_ready", 32'(req_ready_o), 32'd0);
    wait_rsp(1, lat);
    check_rsp("rw", 2, 32'h1234_0000, 1'b0, 5'd5);
    chk("rw_mtvec", mtvec_m, 32'h8000_0000);
    chk("rw_wrcnt", 32'(wr_cnt), 32'd1);

    // CSRRS mie |= 0x888
    send(CSRRS, 12'h304, 32'h888, 5'd2, 5'd3);
    chk("rs_cmd1", 32'(csr_command_o), 32'(READ_ONLY));
    @(posedge clock_i); #1;
    chk("rs_cmd2",   32'(csr_command_o), 32'(WRITE_ONLY));
    chk("rs_wdata2", csr_write_data_o, 32'h888);
    wait_rsp(2, lat);
    check_rsp("rs", 3, 32'h0, 1'b0, 5'd3);
    chk("rs_mie",   mie_m, 32'h888);
    chk("rs_wrcnt", 32'(wr_cnt), 32'd2);

    // CSRRCI mie, uimm=0: pure read
    send(CSRRCI, 12'h304, 32'hFFFF_FFFF, 5'd0, 5'd6);
    chk("rci0_cmd", 32'(csr_command_o), 32'(READ_ONLY));
    wait_rsp(1, lat);
    check_rsp("rci0", 2, 32'h888, 1'b0, 5'd6);
    chk("rci0_wrcnt", 32'(wr_cnt), 32'd2);

    // CSRRC mie &= ~0x808
    send(CSRRC, 12'h304, 32'h808, 5'd4, 5'd9);
    chk("rc_cmd1", 32'(csr_command_o), 32'(READ_ONLY));
    @(posedge clock_i); #1;
    chk("rc_cmd2",   32'(csr_command_o), 32'(WRITE_ONLY));
    chk("rc_wdata2", csr_write_data_o, 32'h080);
    wait_rsp(2, lat);
    check_rsp("rc", 3, 32'h888, 1'b0, 5'd9);
    chk("rc_wrcnt", 32'(wr_cnt), 32'd3);

    // CSRRWI mtvec uimm=31, rd=0: write only, zero result
    send(CSRRWI, 12'h305, 32'hDEAD_BEEF, 5'd31, 5'd0);
    chk("rwi_cmd",   32'(csr_command_o), 32'(WRITE_ONLY));
    chk("rwi_wdata", csr_write_data_o, 32'h1F);
    wait_rsp(1, lat);
    check_rsp("rwi", 2, 32'h0, 1'b0, 5'd0);
    chk("rwi_mtvec", mtvec_m, 32'h1F);

    // CSRRW to read-only mvendorid: illegal
    send(CSRRW, 12'hF11, 32'h55, 5'd1, 5'd7);
    chk("ro_cmd", 32'(csr_command_o), 32'(NONE));
    wait_rsp(1, lat);
    check_rsp("ro", 2, 32'h0, 1'b1, 5'd7);

    // CSRRS rs1=x0 on read-only CSR is a legal read
    send(CSRRS, 12'hF11, 32'h0, 5'd0, 5'd12);
    chk("ror_cmd", 32'(csr_command_o), 32'(READ_ONLY));
    wait_rsp(1, lat);
    check_rsp("ror", 2, 32'hABC, 1'b0, 5'd12);

    // CSRRS to nonexistent CSR
    send(CSRRS, 12'h7C0, 32'hFF, 5'd3, 5'd8);
    chk("nx_cmd", 32'(csr_command_o), 32'(READ_ONLY));
    wait_rsp(1, lat);
    check_rsp("nx", 2, 32'h0, 1'b1, 5'd8);

    // funct3=100 is reserved
    send(3'b100, 12'h305, 32'h1, 5'd1, 5'd2);
    chk("f3_cmd", 32'(csr_command_o), 32'(NONE));
    wait_rsp(1, lat);
    check_rsp("f3", 2, 32'h0, 1'b1, 5'd2);
    chk("ill_wrcnt", 32'(wr_cnt), 32'd4);

    // Backpressure: response held for 4 cycles
    rsp_ready_i = 1'b0;
    send(CSRRSI, 12'h304, 32'h0, 5'd0, 5'd10);
    wait_rsp(1, lat);
    chk("bp_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock_i); #1;
      chk("bp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_data",  rsp_rd_data_o, 32'h080);
      chk("bp_rd",    32'(rsp_rd_index_o), 32'd10);
      chk("bp_ready", 32'(req_ready_o), 32'd0);
    end
    @(negedge clock_i) rsp_ready_i = 1'b1;
    @(posedge clock_i); #1;
    chk("bp_release_valid", 32'(rsp_valid_o), 32'd0);
    chk("bp_release_ready", 32'(req_ready_o), 32'd1);

    // Reset while the WRITE command is on the bus, before its write edge
    send(CSRRSI, 12'h304, 32'h0, 5'd1, 5'd11);
    @(posedge clock_i); #1;
    chk("ab_cmd2", 32'(csr_command_o), 32'(WRITE_ONLY));
    reset_ni = 1'b0;
    #1;
    chk("ab_cmd_rst", 32'(csr_command_o), 32'(NONE));
    repeat (2) @(posedge clock_i);
    @(negedge clock_i) reset_ni = 1'b1;
    repeat (2) @(posedge clock_i);
    #1;
    chk("ab_valid", 32'(rsp_valid_o), 32'd0);
    chk("ab_ready", 32'(req_ready_o), 32'd1);
    chk("ab_mie",   mie_m, 32'h080);
    chk("ab_wrcnt", 32'(wr_cnt), 32'd4);

    // Unit still serves requests after the abort
    send(CSRRS, 12'h304, 32'h0, 5'd0, 5'd13);
    wait_rsp(1, lat);
    check_rsp("post", 2, 32'h080, 1'b0, 5'd13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
